crossover: RTL and testbench
============================

# crossover

Single-point crossover stage of the genetic-algorithm datapath. Accepts a pair of 8-bit signed parent chromosomes over a valid/ready handshake. With probability XOVER_RATE/256 it swaps their low bits below a pseudo-random cut point; otherwise it passes the parents through unchanged. Its registered outputs drive `orig_child1`/`orig_child2` of the downstream mutation stage.

## Interface
- SEED, 32'hA1EF_CDE5, initial value of the internal 32-bit LFSR. A value of 0 loads 32'h0000_0001 instead.
- XOVER_RATE, 9'd217, crossover threshold in 1/256 units, range 0..256. 0 means never cross; 256 means always cross.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- parent1  in  8  signed parent A
- parent2  in  8  signed parent B
- in_valid  in  1  parent pair valid
- in_ready  out  1  stage can accept a pair this cycle
- child1  out  8  signed offspring A (registered)
- child2  out  8  signed offspring B (registered)
- out_valid  out  1  child pair valid
- out_ready  in  1  downstream accepts the child pair
- crossed  out  1  1 when the current child pair was produced by a swap
- cut_point  out  3  cut point used for the current pair (1..7), or 0 if no swap
- pair_count  out  16  number of pairs accepted since reset; wraps 16'hFFFF -> 0

## Operation
- Accept condition: `acc = in_valid && in_ready`. `in_ready = !out_valid || out_ready`, driven combinationally.
- LFSR `lfsr[31:0]` is a Fibonacci LFSR:
  - `fb = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]`.
  - Step: `lfsr <= {lfsr[30:0], fb}`.
  - It steps only on `acc`. The pre-step value is used for that pair.
- Per accepted pair, with `r` = current lfsr:
  - `do_x = (r[7:0] < XOVER_RATE)`, an unsigned compare at 9 bits.
  - `c = (r[10:8] % 7) + 1`, so c is in 1..7. An r[10:8] value of 7 maps to c = 1.
  - `m = (8'h1 << c) - 1`.
  - If do_x:
    - child1 <= (parent1 & ~m) | (parent2 & m).
    - child2 <= (parent2 & ~m) | (parent1 & m).
    - crossed <= 1; cut_point <= c.
  - Else:
    - child1 <= parent1; child2 <= parent2.
    - crossed <= 0; cut_point <= 0.
- Bit operations are on raw bits. Sign carries no meaning here.
- Output register:
  - out_valid <= 1 on acc.
  - Else out_valid <= 0 when out_ready.
  - Else it holds.
- Data, crossed and cut_point load only on acc. They are held stable while `out_valid && !out_ready`.
- pair_count increments by 1 on each acc, with modulo-2^16 wrap.

## Timing
- Latency: an input accepted in cycle N appears on the outputs with out_valid = 1 in cycle N+1.
- Throughput: one pair per cycle while out_ready = 1.
- Accept and drain in the same cycle: when out_valid && out_ready && in_valid, the new pair replaces the old with no bubble and out_valid stays 1.
- Backpressure: when out_valid && !out_ready:
  - in_ready = 0.
  - lfsr and pair_count do not change.
  - parent inputs are ignored.
- Reset values, applied on the clk edge when reset = 0:
  - out_valid = 0, child1 = child2 = 0, crossed = 0, cut_point = 0, pair_count = 0.
  - lfsr = SEED, or 1 if SEED == 0.
- Reset mid-transfer drops any held pair. in_ready = 1 in the first cycle after reset deasserts.
- in_valid is ignored in any cycle where reset = 0.

## Test plan
- Fixed-seed swap: SEED = default, XOVER_RATE = 256, parent1 = 8'h00, parent2 = 8'hFF.
  - Expected: r[10:8] = 5, so c = 6.
  - Next cycle: child1 = 8'h3F, child2 = 8'hC0, crossed = 1, cut_point = 6, pair_count = 1.
- Pass-through: SEED = default, XOVER_RATE = 12, same parents.
  - r[7:0] = 8'hE5 is not < 12.
  - Expected: child1 = 8'h00, child2 = 8'hFF, crossed = 0, cut_point = 0.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1.
  - Expected: in_ready = 0; outputs, lfsr and pair_count are frozen.
  - On release, the next pair is accepted with no loss or duplication. A scoreboard checks all pairs against a reference model.
- Streaming: 70000 random pairs with out_ready = 1.
  - Expected: one output per cycle; pair_count wraps to 4464.
  - Measured crossed ratio for XOVER_RATE = 128 falls within 0.5 ± 0.02.
  - cut_point values cover 1..7, with 1 at double frequency.
- Reset mid-stream: assert reset = 0 while out_valid = 1 && out_ready = 0.
  - Expected: next cycle out_valid = 0 and pair_count = 0.
  - The first post-reset pair reproduces the fixed-seed swap result.
- Zero seed: SEED = 0.
  - Expected: lfsr starts at 1 and does not lock up. A 1000-pair run shows the LFSR is never 0 after any step.

Source files
------------

// File: rtl/crossover.sv
// Single-point crossover: swaps the low bits of two parent chromosomes below an LFSR-chosen cut.
// Latency: 1 cycle; a pair accepted in cycle N is presented with out_valid in cycle N+1.
// Backpressure: in_ready = !out_valid || out_ready; while stalled, outputs, LFSR and count hold.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   parent1/2, in_valid  input pair and its valid; in_ready indicates acceptance
//   child1/2, out_valid  registered offspring pair; out_ready from downstream
//   crossed, cut_point   swap flag and cut (1..7, or 0 on pass-through) for the current pair
//   pair_count          pairs accepted since reset, wraps modulo 2^16
module crossover #(
   parameter logic [31:0] SEED       = 32'hA1EF_CDE5,
   parameter logic [8:0]  XOVER_RATE = 9'd217
) (
   input  logic              clk,
   input  logic              reset,
   input  logic signed [7:0] parent1,
   input  logic signed [7:0] parent2,
   input  logic              in_valid,
   output logic              in_ready,
   output logic signed [7:0] child1,
   output logic signed [7:0] child2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              crossed,
   output logic [2:0]        cut_point,
   output logic [15:0]       pair_count
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

   logic [31:0] lfsr_q, lfsr_d;
   logic [7:0]  child1_q, child1_d;
   logic [7:0]  child2_q, child2_d;
   logic        out_valid_q, out_valid_d;
   logic        crossed_q, crossed_d;
   logic [2:0]  cut_q, cut_d;
   logic [15:0] count_q, count_d;

   logic        acc;
   logic        fb;
   logic        do_x;
   logic [2:0]  cut;
   logic [7:0]  mask;
   logic [7:0]  p1_bits, p2_bits;

   assign in_ready = !out_valid_q || out_ready;
   assign acc      = in_valid && in_ready;

   // Sign is irrelevant to crossover; work on raw bits.
   assign p1_bits = parent1;
   assign p2_bits = parent2;

   assign fb   = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
   assign do_x = {1'b0, lfsr_q[7:0]} < XOVER_RATE;
   // Raw value 7 folds onto cut 1, so cut 1 occurs twice as often as the others.
   assign cut  = (lfsr_q[10:8] % 3'd7) + 3'd1;
   assign mask = (8'h01 << cut) - 8'h01;

   always_comb begin
      lfsr_d      = lfsr_q;
      child1_d    = child1_q;
      child2_d    = child2_q;
      out_valid_d = out_valid_q;
      crossed_d   = crossed_q;
      cut_d       = cut_q;
      count_d     = count_q;
      if (acc) begin
         // The pre-step LFSR value decides this pair; the step takes effect for the next one.
         lfsr_d      = {lfsr_q[30:0], fb};
         out_valid_d = 1'b1;
         count_d     = count_q + 16'd1;
         if (do_x) begin
            child1_d  = (p1_bits & ~mask) | (p2_bits & mask);
            child2_d  = (p2_bits & ~mask) | (p1_bits & mask);
            crossed_d = 1'b1;
            cut_d     = cut;
         end else begin
            child1_d  = p1_bits;
            child2_d  = p2_bits;
            crossed_d = 1'b0;
            cut_d     = 3'd0;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_q      <= SEED_EFF;
         child1_q    <= 8'd0;
         child2_q    <= 8'd0;
         out_valid_q <= 1'b0;
         crossed_q   <= 1'b0;
         cut_q       <= 3'd0;
         count_q     <= 16'd0;
      end else begin
         lfsr_q      <= lfsr_d;
         child1_q    <= child1_d;
         child2_q    <= child2_d;
         out_valid_q <= out_valid_d;
         crossed_q   <= crossed_d;
         cut_q       <= cut_d;
         count_q     <= count_d;
      end
   end

   assign child1     = child1_q;
   assign child2     = child2_q;
   assign out_valid  = out_valid_q;
   assign crossed    = crossed_q;
   assign cut_point  = cut_q;
   assign pair_count = count_q;

endmodule

// File: tb/tb_crossover.sv
// Scoreboard bench for crossover: four instances (rate 128, rate 256, rate 12, zero seed)
// share one stimulus stream; rate-128 and zero-seed instances are checked pair by pair
// against a reference model, the other two at the fixed-seed checkpoints.
module tb_crossover;

   localparam logic [31:0] SEED_DEF = 32'hA1EF_CDE5;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] p1, p2;
   logic       iv, ordy;

   logic [7:0] m_c1, m_c2, a_c1, a_c2, b_c1, b_c2, z_c1, z_c2;
   logic       m_ov, a_ov, b_ov, z_ov;
   logic       m_ir, a_ir, b_ir, z_ir;
   logic       m_x, a_x, b_x, z_x;
   logic [2:0] m_cut, a_cut, b_cut, z_cut;
   logic [15:0] m_cnt, a_cnt, b_cnt, z_cnt;

   crossover #(.XOVER_RATE(9'd128)) u_main (
      .clk(clk), .reset(reset), .parent1(p1), .parent2(p2), .in_valid(iv), .in_ready(m_ir),
      .child1(m_c1), .child2(m_c2), .out_valid(m_ov), .out_ready(ordy), .crossed(m_x),
      .cut_point(m_cut), .pair_count(m_cnt));
   crossover #(.XOVER_RATE(9'd256)) u_r256 (
      .clk(clk), .reset(reset), .parent1(p1), .parent2(p2), .in_valid(iv), .in_ready(a_ir),
      .child1(a_c1), .child2(a_c2), .out_valid(a_ov), .out_ready(ordy), .crossed(a_x),
      .cut_point(a_cut), .pair_count(a_cnt));
   crossover #(.XOVER_RATE(9'd12)) u_r12 (
      .clk(clk), .reset(reset), .parent1(p1), .parent2(p2), .in_valid(iv), .in_ready(b_ir),
      .child1(b_c1), .child2(b_c2), .out_valid(b_ov), .out_ready(ordy), .crossed(b_x),
      .cut_point(b_cut), .pair_count(b_cnt));
   crossover #(.SEED(32'd0), .XOVER_RATE(9'd128)) u_z (
      .clk(clk), .reset(reset), .parent1(p1), .parent2(p2), .in_valid(iv), .in_ready(z_ir),
      .child1(z_c1), .child2(z_c2), .out_valid(z_ov), .out_ready(ordy), .crossed(z_x),
      .cut_point(z_cut), .pair_count(z_cnt));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state: {crossed, cut[2:0], child1, child2, count}
   logic [31:0] mdl_lfsr_m, mdl_lfsr_z;
   logic [15:0] mdl_cnt;
   logic [35:0] qm[$];
   logic [35:0] qz[$];
   int          zchk_left = 0;
   bit          stat_en = 0;
   int          n_stat = 0, x_cnt = 0;
   int          cut_hist[8];

   function automatic logic [31:0] lfsr_next(input logic [31:0] r);
      return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
   endfunction

   function automatic logic [35:0] expect_pair(input logic [31:0] r, input logic [8:0] rate,
                                                input logic [7:0] a, input logic [7:0] b,
                                                input logic [15:0] cnt);
      logic [2:0] c;
      logic [7:0] m;
      logic [7:0] e1, e2;
      if ({1'b0, r[7:0]} < rate) begin
         c  = (r[10:8] == 3'd7) ? 3'd1 : r[10:8] + 3'd1;
         m  = 8'hFF >> (4'd8 - {1'b0, c});
         e1 = 8'h00;
         e2 = 8'h00;
         for (int i = 0; i < 8; i++) begin
            e1[i] = m[i] ? b[i] : a[i];
            e2[i] = m[i] ? a[i] : b[i];
         end
         return {1'b1, c, e1, e2, cnt};
      end
      return {1'b0, 3'd0, a, b, cnt};
   endfunction

   // One clock of stimulus: drive at the falling edge, then score what the rising edge will take.
   task automatic step(input logic rst, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
      logic [35:0] e;
      @(negedge clk);
      reset = rst; iv = v; p1 = a; p2 = b; ordy = rdy;
      #1;
      if (zchk_left > 0 && rst) begin
         chk("z_lfsr_nonzero", 64'(u_z.lfsr_q != 32'd0), 64'd1);
         zchk_left--;
      end
      if (!rst) begin
         qm.delete();
         qz.delete();
         mdl_lfsr_m = SEED_DEF;
         mdl_lfsr_z = 32'd1;
         mdl_cnt    = 16'd0;
         zchk_left  = 1000;
      end else begin
         if (m_ov && rdy) begin
            if (qm.size() == 0) chk("sb_main_unexpected", 64'd1, 64'd0);
            else begin
               e = qm.pop_front();
               chk("sb_main", 64'({m_x, m_cut, m_c1, m_c2, m_cnt}), 64'(e));
            end
            if (qz.size() == 0) chk("sb_zero_unexpected", 64'd1, 64'd0);
            else begin
               e = qz.pop_front();
               chk("sb_zero", 64'({z_x, z_cut, z_c1, z_c2, z_cnt}), 64'(e));
            end
            if (stat_en) begin
               n_stat++;
               if (m_x) begin
                  x_cnt++;
                  cut_hist[m_cut]++;
               end
            end
         end
         if (v && m_ir) begin
            mdl_cnt = mdl_cnt + 16'd1;
            qm.push_back(expect_pair(mdl_lfsr_m, 9'd128, a, b, mdl_cnt));
            qz.push_back(expect_pair(mdl_lfsr_z, 9'd128, a, b, mdl_cnt));
            mdl_lfsr_m = lfsr_next(mdl_lfsr_m);
            mdl_lfsr_z = lfsr_next(mdl_lfsr_z);
         end
      end
   endtask

   task automatic check_fixed_swap(input string tag);
      chk({tag, "_c1"},  64'(a_c1), 64'h3F);
      chk({tag, "_c2"},  64'(a_c2), 64'hC0);
      chk({tag, "_x"},   64'(a_x), 64'd1);
      chk({tag, "_cut"}, 64'(a_cut), 64'd6);
      chk({tag, "_cnt"}, 64'(a_cnt), 64'd1);
      chk({tag, "_ov"},  64'(a_ov), 64'd1);
   endtask

   initial begin
      int stalls;
      reset = 1'b0; iv = 1'b0; p1 = 8'h00; p2 = 8'h00; ordy = 1'b1;
      for (int i = 0; i < 8; i++) cut_hist[i] = 0;

      repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      chk("rst_ov",   64'(m_ov), 64'd0);
      chk("rst_c1",   64'(m_c1), 64'd0);
      chk("rst_c2",   64'(m_c2), 64'd0);
      chk("rst_x",    64'(m_x), 64'd0);
      chk("rst_cut",  64'(m_cut), 64'd0);
      chk("rst_cnt",  64'(m_cnt), 64'd0);
      chk("rst_ir",   64'(m_ir), 64'd1);
      chk("z_seed",   64'(u_z.lfsr_q), 64'd1);

      // Fixed-seed swap (rate 256) and pass-through (rate 12) with parents 00/FF.
      step(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      check_fixed_swap("fix");
      chk("pass_c1",  64'(b_c1), 64'h00);
      chk("pass_c2",  64'(b_c2), 64'hFF);
      chk("pass_x",   64'(b_x), 64'd0);
      chk("pass_cut", 64'(b_cut), 64'd0);

      // Backpressure: one pair accepted, then 5 stalled cycles with in_valid high.
      step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
         chk("bp_in_ready", 64'(m_ir), 64'd0);
         chk("bp_ov",       64'(m_ov), 64'd1);
         if (qm.size() != 0)
            chk("bp_hold", 64'({m_x, m_cut, m_c1, m_c2, m_cnt}), 64'(qm[0]));
         chk("bp_lfsr",     64'(u_main.lfsr_q), 64'(mdl_lfsr_m));
         chk("bp_cnt",      64'(m_cnt), 64'(mdl_cnt));
      end
      step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);

      // Mixed random valid/ready traffic.
      for (int i = 0; i < 2000; i++)
         step(1'b1, ($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 3) != 0);
      repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      chk("mix_drained", 64'(qm.size()), 64'd0);

      // Reset while a pair is held under backpressure.
      step(1'b1, 1'b1, 8'h5A, 8'hA5, 1'b0);
      step(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
      chk("pre_rst_ov", 64'(m_ov), 64'd1);
      step(1'b0, 1'b1, 8'h33, 8'h44, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      chk("mid_rst_ov",  64'(m_ov), 64'd0);
      chk("mid_rst_cnt", 64'(m_cnt), 64'd0);
      chk("mid_rst_ir",  64'(m_ir), 64'd1);
      step(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      check_fixed_swap("post_rst");

      // Streaming: 69999 more pairs make 70000 since reset, so the count wraps to 4464.
      stat_en = 1'b1;
      stalls  = 0;
      for (int i = 0; i < 69999; i++) begin
         step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
         if (i > 0 && !m_ov) stalls++;
      end
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      stat_en = 1'b0;
      chk("stream_stalls",  64'(stalls), 64'd0);
      chk("stream_outputs", 64'(n_stat), 64'd69999);
      chk("stream_wrap",    64'(m_cnt), 64'd4464);
      chk("stream_drained", 64'(qm.size()), 64'd0);
      chk("xover_ratio", 64'((x_cnt * 1000 / n_stat) >= 480 && (x_cnt * 1000 / n_stat) <= 520), 64'd1);
      chk("cut_zero_never", 64'(cut_hist[0]), 64'd0);
      chk("cut1_seen", 64'(cut_hist[1] > 0), 64'd1);
      for (int k = 2; k < 8; k++) begin
         chk("cut_seen", 64'(cut_hist[k] > 0), 64'd1);
         chk("cut1_double", 64'((cut_hist[1] * 10 >= cut_hist[k] * 17) &&
                                (cut_hist[1] * 10 <= cut_hist[k] * 23)), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
